// File: rtl/iter_shift_unit_if.sv
// Start/operand/result bundle for iter_shift_unit.
// The requester drives the master side and the shifter sits on the slave side.
interface iter_shift_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               ctrl_shift;
  logic               op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               data_ready;
  logic               busy;

  modport master (
    output ctrl_shift, op, data_in, shamt,
    input  result, data_ready, busy
  );

  modport slave (
    input  ctrl_shift, op, data_in, shamt,
    output result, data_ready, busy
  );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRA shifter: shifts one bit position per clock.
// It latches the operand on a start pulse and gives a one-cycle data_ready strobe.
module iter_shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic              clock,
  input logic              reset,
  iter_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   shift1;

  // op_q: 0 = SLL with zero fill, 1 = SRA with sign fill.
  always_comb begin
    if (op_q) begin
      shift1 = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    end else begin
      shift1 = {result_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.ctrl_shift) begin
          result_d = bus.data_in;
          count_d  = bus.shamt;
          op_d     = bus.op;
          state_d  = (bus.shamt != '0) ? StShift : StDone;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // A start pulse is ignored here; the shift in progress runs to completion.
        result_d = shift1;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign bus.result     = result_q;
  assign bus.busy       = (state_q == StShift);
  assign bus.data_ready = (state_q == StDone);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit.
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_iter_shift_unit;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  iter_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advances to 1 time unit past the next rising edge, where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Applies a one-cycle start pulse, then scrambles the operands to show they were latched.
  task automatic start(input logic op, input logic [31:0] data, input logic [4:0] sh);
    bus.ctrl_shift = 1'b1;
    bus.op         = op;
    bus.data_in    = data;
    bus.shamt      = sh;
    tick();
    bus.ctrl_shift = 1'b0;
    bus.op         = ~op;
    bus.data_in    = ~data;
    bus.shamt      = ~sh;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.result !== 32'h0) begin
      errors++; $display("FAIL reset_result got %h want %h", bus.result, 32'h0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.data_ready !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b ready=%b want 0 0", bus.busy, bus.data_ready);
    end
  endtask

  task automatic test_sra_4();
    int n;
    start(1'b1, 32'h8000_0000, 5'd4);
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++; $display("FAIL sra4_busy cycle %0d got %b want 1", n, bus.busy);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL sra4_latency got %0d want 4", n);
    end
    checks++;
    if (bus.result !== 32'hF800_0000) begin
      errors++; $display("FAIL sra4_result got %h want %h", bus.result, 32'hF800_0000);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL sra4_busy_at_ready got %b want 0", bus.busy);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b0 || bus.result !== 32'hF800_0000) begin
      errors++; $display("FAIL sra4_after got ready=%b result=%h want 0 f8000000",
                         bus.data_ready, bus.result);
    end
  endtask

  task automatic test_sll_31();
    int n;
    start(1'b0, 32'h0000_0001, 5'd31);
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 31) begin
      errors++; $display("FAIL sll31_latency got %0d want 31", n);
    end
    checks++;
    if (bus.result !== 32'h8000_0000) begin
      errors++; $display("FAIL sll31_result got %h want %h", bus.result, 32'h8000_0000);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b0) begin
      errors++; $display("FAIL sll31_strobe_width got ready=%b want 0", bus.data_ready);
    end
  endtask

  task automatic test_sra_0();
    start(1'b1, 32'h7FFF_FFF0, 5'd0);
    checks++;
    if (bus.data_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL sra0_flags got ready=%b busy=%b want 1 0", bus.data_ready, bus.busy);
    end
    checks++;
    if (bus.result !== 32'h7FFF_FFF0) begin
      errors++; $display("FAIL sra0_result got %h want %h", bus.result, 32'h7FFF_FFF0);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL sra0_idle got ready=%b busy=%b want 0 0", bus.data_ready, bus.busy);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    start(1'b0, 32'h0000_FFFF, 5'd8);
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      if (n == 2) begin
        bus.ctrl_shift = 1'b1;
        bus.op         = 1'b1;
        bus.data_in    = 32'h1234_5678;
        bus.shamt      = 5'd3;
      end
      tick();
      bus.ctrl_shift = 1'b0;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL ignore_latency got %0d want 8", n);
    end
    checks++;
    if (bus.result !== 32'h00FF_FF00) begin
      errors++; $display("FAIL ignore_result got %h want %h", bus.result, 32'h00FF_FF00);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int strobes;
    start(1'b1, 32'hFFFF_0000, 5'd16);
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_busy_before got %b want 1", bus.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.data_ready !== 1'b0 || bus.result !== 32'h0) begin
      errors++; $display("FAIL midrst_state got busy=%b ready=%b result=%h want 0 0 0",
                         bus.busy, bus.data_ready, bus.result);
    end
    strobes = 0;
    repeat (20) begin
      tick();
      if (bus.data_ready === 1'b1 || bus.busy === 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL midrst_no_ready got %0d active cycles want 0", strobes);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start(1'b0, 32'h0000_0003, 5'd2);
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 || bus.result !== 32'h0000_000C) begin
      errors++; $display("FAIL b2b_first got n=%0d result=%h want 2 0000000c", n, bus.result);
    end
    start(1'b1, 32'h8000_0001, 5'd1);
    checks++;
    if (bus.data_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got ready=%b busy=%b want 0 1", bus.data_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b1 || bus.result !== 32'hC000_0000) begin
      errors++; $display("FAIL b2b_second got ready=%b result=%h want 1 c0000000",
                         bus.data_ready, bus.result);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b0 || bus.result !== 32'hC000_0000) begin
      errors++; $display("FAIL b2b_hold got ready=%b result=%h want 0 c0000000",
                         bus.data_ready, bus.result);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.ctrl_shift = 1'b0;
    bus.op         = 1'b0;
    bus.data_in    = '0;
    bus.shamt      = '0;
    test_reset();
    test_sra_4();
    test_sll_31();
    test_sra_0();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
